// File: rtl/conv3x3_stream_if.sv
// Pixel stream interface for conv3x3_stream: raster input beats in, filtered pixels out.
interface conv3x3_stream_if #(
    parameter int PIXEL_WIDTH = 8
);
    logic [PIXEL_WIDTH-1:0] pixel_in;
    logic                   valid_in;
    logic                   sof_in;
    logic [PIXEL_WIDTH-1:0] pixel_out;
    logic                   valid_out;
    logic                   last_out;

    modport master (
        output pixel_in,
        output valid_in,
        output sof_in,
        input  pixel_out,
        input  valid_out,
        input  last_out
    );

    modport slave (
        input  pixel_in,
        input  valid_in,
        input  sof_in,
        output pixel_out,
        output valid_out,
        output last_out
    );
endinterface

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over a raster image: two line buffers, a 3x3 window
// register, a product stage and a sum/shift/clamp output stage (3-cycle latency).
module conv3x3_stream #(
    parameter int IMG_WIDTH    = 32,
    parameter int IMG_HEIGHT   = 32,
    parameter int PIXEL_WIDTH  = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int FRAC_BITS    = 5
) (
    input  logic                                    clk_in,
    input  logic                                    rst_in,
    input  logic signed [2:0][2:0][WEIGHT_WIDTH-1:0] weight_in,
    conv3x3_stream_if.slave                         strm
);
    localparam int CW  = $clog2(IMG_WIDTH);
    localparam int RW  = $clog2(IMG_HEIGHT);
    localparam int PRW = WEIGHT_WIDTH + PIXEL_WIDTH + 1;
    localparam int SW  = PRW + 4;
    localparam logic signed [SW-1:0] MAX_S = SW'((1 << PIXEL_WIDTH) - 1);

    logic [CW-1:0]          col_r, cur_col_s, nxt_col_s;
    logic [RW-1:0]          row_r, cur_row_s, nxt_row_s;
    logic [PIXEL_WIDTH-1:0] lb1_r [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] lb2_r [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] lb1_rd_s, lb2_rd_s;
    logic [PIXEL_WIDTH-1:0] win_r [3][3];
    logic                   v1_r, last1_r, v2_r, last2_r;
    logic signed [PRW-1:0]  prod_s [9];
    logic signed [PRW-1:0]  prod_r [9];
    logic signed [SW-1:0]   sum_s, shifted_s;
    logic [PIXEL_WIDTH-1:0] clamp_s;
    logic [PIXEL_WIDTH-1:0] pixel_out_r;
    logic                   valid_out_r, last_out_r;

    // Beat position: a qualified start-of-frame forces (0,0), then compute the successor.
    always_comb begin
        if (strm.sof_in) begin
            cur_col_s = {CW{1'b0}};
            cur_row_s = {RW{1'b0}};
        end else begin
            cur_col_s = col_r;
            cur_row_s = row_r;
        end
        if (cur_col_s == CW'(IMG_WIDTH - 1)) begin
            nxt_col_s = {CW{1'b0}};
            if (cur_row_s == RW'(IMG_HEIGHT - 1)) begin
                nxt_row_s = {RW{1'b0}};
            end else begin
                nxt_row_s = cur_row_s + RW'(1);
            end
        end else begin
            nxt_col_s = cur_col_s + CW'(1);
            nxt_row_s = cur_row_s;
        end
        lb1_rd_s = lb1_r[cur_col_s];
        lb2_rd_s = lb2_r[cur_col_s];
    end

    // Position counters and stage-1 valid/last flags.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            col_r   <= {CW{1'b0}};
            row_r   <= {RW{1'b0}};
            v1_r    <= 1'b0;
            last1_r <= 1'b0;
        end else if (strm.valid_in) begin
            col_r   <= nxt_col_s;
            row_r   <= nxt_row_s;
            v1_r    <= (cur_row_s >= RW'(2)) && (cur_col_s >= CW'(2));
            last1_r <= (cur_row_s == RW'(IMG_HEIGHT - 1)) && (cur_col_s == CW'(IMG_WIDTH - 1));
        end else begin
            v1_r    <= 1'b0;
            last1_r <= 1'b0;
        end
    end

    // Line buffers and window move only on accepted beats; their contents need no reset.
    always_ff @(posedge clk_in) begin
        if (strm.valid_in) begin
            lb2_r[cur_col_s] <= lb1_rd_s;
            lb1_r[cur_col_s] <= strm.pixel_in;
            for (int r = 0; r < 3; r++) begin
                win_r[r][0] <= win_r[r][1];
                win_r[r][1] <= win_r[r][2];
            end
            win_r[0][2] <= lb2_rd_s;
            win_r[1][2] <= lb1_rd_s;
            win_r[2][2] <= strm.pixel_in;
        end else begin
            lb1_r <= lb1_r;
            lb2_r <= lb2_r;
            win_r <= win_r;
        end
    end

    // Zero-extended pixel times sign-extended weight, weights sampled at this stage.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                prod_s[r*3+c] = $signed(PRW'({1'b0, win_r[r][c]}))
                              * $signed(PRW'($signed(weight_in[r][c])));
            end
        end
    end

    // Product register and stage-2 flags.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            v2_r    <= 1'b0;
            last2_r <= 1'b0;
        end else begin
            v2_r    <= v1_r;
            last2_r <= last1_r;
        end
        if (v1_r) begin
            prod_r <= prod_s;
        end else begin
            prod_r <= prod_r;
        end
    end

    // Full-precision sum, arithmetic shift to integer, clamp to the pixel range.
    always_comb begin
        sum_s = {SW{1'b0}};
        for (int i = 0; i < 9; i++) begin
            sum_s = sum_s + SW'(prod_r[i]);
        end
        shifted_s = sum_s >>> FRAC_BITS;
        if (shifted_s[SW-1]) begin
            clamp_s = {PIXEL_WIDTH{1'b0}};
        end else if (shifted_s > MAX_S) begin
            clamp_s = {PIXEL_WIDTH{1'b1}};
        end else begin
            clamp_s = shifted_s[PIXEL_WIDTH-1:0];
        end
    end

    // Output register; pixel_out holds its last value between results.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_out_r <= 1'b0;
            last_out_r  <= 1'b0;
            pixel_out_r <= {PIXEL_WIDTH{1'b0}};
        end else begin
            valid_out_r <= v2_r;
            last_out_r  <= v2_r && last2_r;
            if (v2_r) begin
                pixel_out_r <= clamp_s;
            end else begin
                pixel_out_r <= pixel_out_r;
            end
        end
    end

    assign strm.pixel_out = pixel_out_r;
    assign strm.valid_out = valid_out_r;
    assign strm.last_out  = last_out_r;
endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream on a 4x4 image with FRAC_BITS=5.
module tb_conv3x3_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [2:0][2:0][7:0] weight;

    conv3x3_stream_if #(.PIXEL_WIDTH(8)) bus ();

    conv3x3_stream #(
        .IMG_WIDTH(4), .IMG_HEIGHT(4), .PIXEL_WIDTH(8), .WEIGHT_WIDTH(8), .FRAC_BITS(5)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .weight_in(weight),
        .strm(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int log_n = 0;
    int lg_px [64];
    int lg_last [64];
    int lg_stamp [64];
    int frame_px [16];
    int bstamp [16];
    int gap_tab [16] = '{0, 2, 1, 0, 3, 0, 1, 2, 0, 0, 1, 3, 2, 0, 1, 0};
    int base;

    always @(posedge clk) cyc <= cyc + 1;

    // Output log: value, last flag and the cycle in which the result is visible.
    always @(negedge clk) begin
        if (bus.valid_out && log_n < 64) begin
            lg_px[log_n]    <= int'(bus.pixel_out);
            lg_last[log_n]  <= int'(bus.last_out);
            lg_stamp[log_n] <= cyc + 1;
            log_n           <= log_n + 1;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_w(input int ctr, input int oth);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                weight[r][c] = (r == 1 && c == 1) ? 8'(ctr) : 8'(oth);
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < 16; i++) frame_px[i] = v;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 16; i++) frame_px[i] = i;
    endtask

    // Drive nbeats raster beats; idle gaps carry junk pixels and an unqualified sof.
    task automatic send_frame(input int nbeats, input bit use_sof, input bit use_gaps);
        for (int i = 0; i < nbeats; i++) begin
            if (use_gaps) begin
                repeat (gap_tab[i]) begin
                    @(negedge clk);
                    bus.valid_in = 1'b0;
                    bus.sof_in   = 1'b1;
                    bus.pixel_in = 8'hAA;
                end
            end
            @(negedge clk);
            bus.valid_in = 1'b1;
            bus.sof_in   = use_sof && (i == 0);
            bus.pixel_in = 8'(frame_px[i]);
            bstamp[i]    = cyc + 1;
        end
        @(negedge clk);
        bus.valid_in = 1'b0;
        bus.sof_in   = 1'b0;
    endtask

    task automatic drain();
        repeat (6) @(negedge clk);
    endtask

    task automatic check_frame(input string name, input int b, input int e0, input int e1,
                               input int e2, input int e3);
        int ev [4];
        int ci [4];
        ev = '{e0, e1, e2, e3};
        ci = '{10, 11, 14, 15};
        check({name, "_count"}, log_n - b, 4);
        for (int k = 0; k < 4; k++) begin
            if (b + k < log_n) begin
                check($sformatf("%s_px%0d", name, k), lg_px[b+k], ev[k]);
                check($sformatf("%s_lat%0d", name, k), lg_stamp[b+k], bstamp[ci[k]] + 3);
                check($sformatf("%s_last%0d", name, k), lg_last[b+k], (k == 3) ? 1 : 0);
            end
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_valid"}, int'(bus.valid_out), 0);
        check({name, "_last"}, int'(bus.last_out), 0);
        check({name, "_pixel"}, int'(bus.pixel_out), 0);
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.sof_in   = 1'b0;
        bus.pixel_in = 8'h00;
        set_w(0, 0);
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        // All weights 1.0, flat 10 -> 9*10
        set_w(32, 32);
        fill_const(10);
        base = log_n;
        send_frame(16, 1'b1, 1'b0);
        drain();
        check_frame("flat10", base, 90, 90, 90, 90);

        // Partial junk frame, then sof must restart at (0,0); identity kernel
        fill_const(77);
        send_frame(5, 1'b0, 1'b0);
        drain();
        set_w(32, 0);
        fill_ramp();
        base = log_n;
        send_frame(16, 1'b1, 1'b0);
        drain();
        check_frame("ramp", base, 5, 6, 9, 10);

        // Saturation high: 2295 clamps to 255
        set_w(32, 32);
        fill_const(255);
        base = log_n;
        send_frame(16, 1'b1, 1'b0);
        drain();
        check_frame("sat_hi", base, 255, 255, 255, 255);

        // Saturation low: -100 clamps to 0
        set_w(-32, 0);
        fill_const(100);
        base = log_n;
        send_frame(16, 1'b1, 1'b0);
        drain();
        check_frame("sat_lo", base, 0, 0, 0, 0);

        // Ramp with idle gaps carrying junk and unqualified sof
        set_w(32, 0);
        fill_ramp();
        base = log_n;
        send_frame(16, 1'b1, 1'b1);
        drain();
        check_frame("gaps", base, 5, 6, 9, 10);

        // Abort after beat (2,3); the (2,2) result is in flight and must be dropped
        fill_const(200);
        base = log_n;
        send_frame(12, 1'b1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_idle("abort");
        rst = 1'b0;
        fill_ramp();
        send_frame(16, 1'b0, 1'b0);
        drain();
        check_frame("post_rst", base, 5, 6, 9, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv3x3_stream.md
CONV3X3_STREAM -- requirements
Module: conv3x3_stream

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 32: pixels per row, minimum 3.
REQ-002 SHALL have parameter IMG_HEIGHT, default 32: rows per frame, minimum 3.
REQ-003 SHALL have parameter PIXEL_WIDTH, default 8: unsigned pixel width.
REQ-004 SHALL have parameter WEIGHT_WIDTH, default 8: signed weight width.
REQ-005 SHALL have parameter FRAC_BITS, default 5: weight fractional bits, so weight 32 = 1.0.
REQ-006 SHALL use one clock and a synchronous, active-high reset.
REQ-007 SHALL have clk_in, input, 1 bit: clock.
REQ-008 SHALL have rst_in, input, 1 bit: synchronous active-high reset.
REQ-009 SHALL have weight_in, input, signed [2:0][2:0][WEIGHT_WIDTH-1:0]: kernel, [row][col], 00 = top-left.
REQ-010 SHALL have pixel_in, input, PIXEL_WIDTH: raster-order input pixel.
REQ-011 SHALL have valid_in, input, 1 bit: pixel_in is valid this cycle.
REQ-012 SHALL have sof_in, input, 1 bit: start of frame, qualified by valid_in.
REQ-013 SHALL have pixel_out, output, PIXEL_WIDTH: filtered pixel.
REQ-014 SHALL have valid_out, output, 1 bit: pixel_out is valid.
REQ-015 SHALL have last_out, output, 1 bit: high with the final output of a frame.

Function
REQ-016 SHALL keep col and row counters that advance on each accepted beat (valid_in=1), with col wrapping at IMG_WIDTH-1 and incrementing row, and row wrapping at IMG_HEIGHT-1 to 0.
REQ-017 SHALL, when valid_in=1 and sof_in=1, treat that beat as (row 0, col 0) regardless of counter state; sof_in with valid_in=0 SHALL be ignored.
REQ-018 SHALL hold two line buffers of IMG_WIDTH pixels (rows r-1, r-2), written and read only on accepted beats.
REQ-019 SHALL form a 3x3 window per accepted beat: column 2 = {line buf r-2, line buf r-1, pixel_in}, with older columns shifted left.
REQ-020 SHALL have no backpressure; idle cycles (valid_in=0) SHALL freeze counters, line buffers and window and insert bubbles.
REQ-021 SHALL produce one output for each accepted beat at row>=2 and col>=2, giving (IMG_WIDTH-2)*(IMG_HEIGHT-2) outputs per frame with no border padding.
REQ-022 SHALL compute each product with pixel zero-extended to signed, WEIGHT_WIDTH+PIXEL_WIDTH+1 bits, where window[r][c] multiplies weight_in[r][c].
REQ-023 SHALL sum the 9 products at full precision (at least +4 bits), arithmetic-shift right by FRAC_BITS, and clamp to [0, 2^PIXEL_WIDTH-1].
REQ-024 SHALL pipeline as: cycle 1 window register, cycle 2 product register, cycle 3 sum/clamp output register; valid_out SHALL assert exactly 3 cycles after the completing input beat.
REQ-025 SHALL sample weight_in in the product stage; weight changes SHALL affect only windows entering that stage afterwards.
REQ-026 SHALL assert last_out with valid_out for the window whose completing beat was (IMG_HEIGHT-1, IMG_WIDTH-1), and only for that window.
REQ-027 SHALL let outputs already in flight when sof_in arrives complete normally.

Reset
REQ-028 SHALL, with rst_in=1 at a clock edge, clear counters to (0,0), clear all pipeline valid bits, and set valid_out=0, last_out=0, pixel_out=0.
REQ-029 SHALL drop in-flight outputs on reset mid-frame; line buffer contents MAY be left uncleared.
REQ-030 SHALL accept the first beat after reset deasserts as (0,0).

Verification (IMG_WIDTH=IMG_HEIGHT=4, FRAC_BITS=5)
REQ-031 SHALL pass: all weights 32, all pixels 10, back-to-back -> exactly 4 outputs of 90, first 3 cycles after beat (2,2), last_out on the 4th.
REQ-032 SHALL pass: center weight 32, others 0, pixel = row*4+col -> outputs 5, 6, 9, 10 in order.
REQ-033 SHALL pass: all weights 32, all pixels 255 -> outputs 255 (clamped from 2295).
REQ-034 SHALL pass: center weight -32, others 0, pixels 100 -> outputs 0 (clamped from -100).
REQ-035 SHALL pass: REQ-032 stimulus with random valid_in gaps -> identical values, each 3 cycles after its completing beat.
REQ-036 SHALL pass: rst_in pulsed after beat (2,3), then a full new frame -> no output from the aborted frame, and the new frame gives the REQ-032 values with last_out once.
